// File: rtl/dmem_port_pkg.sv
// ============================================================================
// fyra_mem_pkg : shared types and lane helpers for the data-memory port
// Rev 1.0
// ============================================================================
`default_nettype none

package fyra_mem_pkg;

  localparam int C_LANES = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  function automatic logic [C_LANES-1:0] be_mask(mem_size_e size, logic [1:0] off);
    logic [C_LANES-1:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(mem_size_e size, logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Replicate right-justified store data so every lane the mask selects sees it.
  function automatic logic [31:0] lane_data(mem_size_e size, logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_port_if.sv
// ============================================================================
// dmem_port_if : request/response bundle between memory controller and port
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_port_if #(
  parameter int SIZE = 12
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic [SIZE-1:0] req_addr;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/dmem_sram.sv
// ============================================================================
// dmem_sram : single-port 32-bit array, byte-lane write enables, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_sram #(
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int C_DEPTH = 2 ** AW;

  logic [31:0] r_mem [C_DEPTH];

  // Read returns the pre-write contents; the port never needs write-through.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      rdata <= r_mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port.sv
// ============================================================================
// dmem_port : load/store memory stage with alignment checks and wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_port #(
  parameter int    SIZE      = 12,
  parameter int    WAIT      = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  dmem_port_if.slave  bus
);

  // The parameter WAIT shadows the state literal, so states are package-scoped.
  localparam logic [2:0] C_WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;
  localparam fyra_mem_pkg::dmem_state_e C_AFTER_ACCEPT =
    (WAIT > 0) ? fyra_mem_pkg::WAIT : fyra_mem_pkg::ACCESS;

  fyra_mem_pkg::dmem_state_e r_state, w_next;
  logic [2:0]                r_cnt;
  logic                      r_we;
  fyra_mem_pkg::mem_size_e   r_size;
  logic [SIZE-1:0]           r_addr;
  logic [31:0]               r_wdata;
  logic [31:0]               r_rdata;
  logic                      r_err;

  logic        w_ready;
  logic        w_rsp_valid;
  logic        w_accept;
  logic [1:0]  w_off;
  logic        w_mis;
  logic        w_mem_en;
  logic        w_mem_we;
  logic [31:0] w_mem_q;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [31:0] w_rsp_rdata;

  assign w_accept = bus.req_valid && w_ready;
  assign w_off    = r_addr[1:0];
  assign w_mis    = fyra_mem_pkg::is_misaligned(r_size, w_off);

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      fyra_mem_pkg::IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) w_next = C_AFTER_ACCEPT;
      end
      fyra_mem_pkg::WAIT: begin
        if (r_cnt == 3'd0) w_next = fyra_mem_pkg::ACCESS;
      end
      fyra_mem_pkg::ACCESS: begin
        w_next = fyra_mem_pkg::RESP;
      end
      fyra_mem_pkg::RESP: begin
        w_ready     = 1'b1;
        w_rsp_valid = 1'b1;
        w_next      = bus.req_valid ? C_AFTER_ACCEPT : fyra_mem_pkg::IDLE;
      end
      default: w_next = fyra_mem_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= fyra_mem_pkg::IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_size  <= fyra_mem_pkg::SZ_B;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_size  <= fyra_mem_pkg::mem_size_e'(bus.req_size);
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= C_WAIT_LOAD;
      end else if (r_state == fyra_mem_pkg::WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (r_state == fyra_mem_pkg::RESP) begin
        r_rdata <= w_rsp_rdata;
        r_err   <= w_mis;
      end
    end
  end

  // Gating on rst keeps a write from landing on the same edge as reset.
  assign w_mem_en = (r_state == fyra_mem_pkg::ACCESS) && !rst;
  assign w_mem_we = r_we && !w_mis;

  dmem_sram #(
    .AW        (SIZE - 2),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (w_mem_we),
    .be    (fyra_mem_pkg::be_mask(r_size, w_off)),
    .addr  (r_addr[SIZE-1:2]),
    .wdata (fyra_mem_pkg::lane_data(r_size, r_wdata)),
    .rdata (w_mem_q)
  );

  assign w_shifted = w_mem_q >> {w_off, 3'b000};

  always_comb begin
    w_load = 32'd0;
    case (r_size)
      fyra_mem_pkg::SZ_B: w_load = {24'd0, w_shifted[7:0]};
      fyra_mem_pkg::SZ_H: w_load = {16'd0, w_shifted[15:0]};
      fyra_mem_pkg::SZ_W: w_load = w_shifted;
      default:            w_load = 32'd0;
    endcase
  end

  assign w_rsp_rdata = (r_we || w_mis) ? 32'd0 : w_load;

  // SRAM data is only valid in RESP, so that cycle drives live and later cycles hold.
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_valid ? w_rsp_rdata : r_rdata;
  assign bus.rsp_err   = w_rsp_valid ? w_mis : r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port.sv
// ============================================================================
// tb_dmem_port : directed checks for dmem_port with WAIT=0 and WAIT=3 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst3 = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  dmem_port_if #(.SIZE(12)) b0 ();
  dmem_port_if #(.SIZE(12)) b3 ();

  dmem_port #(.SIZE(12), .WAIT(0), .INIT_FILE("")) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (b0)
  );

  dmem_port #(.SIZE(12), .WAIT(3), .INIT_FILE("")) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request on the WAIT=0 instance; checks latency, data, error and pulse width.
  task automatic op0(input string tag, input logic we, input logic [1:0] sz,
                     input logic [11:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e);
    int  n;
    bit  got;
    @(posedge clk); #1;
    b0.req_valid = 1'b1;
    b0.req_we    = we;
    b0.req_size  = sz;
    b0.req_addr  = addr;
    b0.req_wdata = wd;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    b0.req_wdata = 32'hx;
    n   = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (b0.rsp_valid) got = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_rdata"}, b0.rsp_rdata, exp_d);
    chk({tag, "_err"}, {31'd0, b0.rsp_err}, {31'd0, exp_e});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, b0.rsp_valid}, 32'd0);
  endtask

  logic [31:0] req_d [4] = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};
  logic [11:0] req_a [4] = '{12'h000, 12'h004, 12'h000, 12'h004};
  logic        req_w [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int          n;
    int          cnt;
    int          nacc;
    int          nrsp;
    int          low_cnt;
    int          rsp_cyc [4];
    logic [31:0] rsp_dat [4];
    bit          acc;

    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_size = 2'b00;
    b0.req_addr  = '0;   b0.req_wdata = 32'd0;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_size = 2'b00;
    b3.req_addr  = '0;   b3.req_wdata = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", {31'd0, b0.req_ready}, 32'd1);
    chk("rst_valid", {31'd0, b0.rsp_valid}, 32'd0);
    chk("rst_rdata", b0.rsp_rdata, 32'd0);
    chk("rst_err",   {31'd0, b0.rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    rst3 = 1'b0;

    // Word store/load
    op0("sw010", 1'b1, 2'b10, 12'h010, 32'hDEADBEEF, 32'd0, 1'b0);
    op0("lw010", 1'b0, 2'b10, 12'h010, 32'd0, 32'hDEADBEEF, 1'b0);
    // Byte store into the top lane
    op0("sb013", 1'b1, 2'b00, 12'h013, 32'h000000AA, 32'd0, 1'b0);
    op0("lw010b", 1'b0, 2'b10, 12'h010, 32'd0, 32'hAAADBEEF, 1'b0);
    op0("lb013", 1'b0, 2'b00, 12'h013, 32'd0, 32'h000000AA, 1'b0);
    // Half store into the upper half
    op0("sh012", 1'b1, 2'b01, 12'h012, 32'h00001234, 32'd0, 1'b0);
    op0("lh012", 1'b0, 2'b01, 12'h012, 32'd0, 32'h00001234, 1'b0);
    op0("lw010c", 1'b0, 2'b10, 12'h010, 32'd0, 32'h1234BEEF, 1'b0);
    op0("lb011", 1'b0, 2'b00, 12'h011, 32'd0, 32'h000000BE, 1'b0);
    op0("lh010", 1'b0, 2'b01, 12'h010, 32'd0, 32'h0000BEEF, 1'b0);
    // Misaligned and reserved-size requests
    op0("lh011", 1'b0, 2'b01, 12'h011, 32'd0, 32'd0, 1'b1);
    op0("sw012", 1'b1, 2'b10, 12'h012, 32'hFFFFFFFF, 32'd0, 1'b1);
    op0("rsv010", 1'b0, 2'b11, 12'h010, 32'd0, 32'd0, 1'b1);
    op0("sbrsv", 1'b1, 2'b11, 12'h010, 32'hFFFFFFFF, 32'd0, 1'b1);
    op0("lw010d", 1'b0, 2'b10, 12'h010, 32'd0, 32'h1234BEEF, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_rdata", b0.rsp_rdata, 32'h1234BEEF);
    chk("hold_valid", {31'd0, b0.rsp_valid}, 32'd0);

    // Reset during ACCESS drops the op and suppresses its write
    op0("sw020", 1'b1, 2'b10, 12'h020, 32'h01020304, 32'd0, 1'b0);
    @(posedge clk); #1;
    b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_size = 2'b10;
    b0.req_addr  = 12'h020; b0.req_wdata = 32'h55555555;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b0.rsp_valid) cnt++;
    end
    chk("rstacc_novalid", 32'(cnt), 32'd0);
    chk("rstacc_ready", {31'd0, b0.req_ready}, 32'd1);
    op0("lw020", 1'b0, 2'b10, 12'h020, 32'd0, 32'h01020304, 1'b0);

    // WAIT=3 instance with req_valid held high across four requests
    @(posedge clk); #1;
    b3.req_valid = 1'b1; b3.req_we = req_w[0]; b3.req_size = 2'b10;
    b3.req_addr  = req_a[0]; b3.req_wdata = req_d[0];
    nacc = 0; nrsp = 0; low_cnt = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      @(negedge clk);
      if (b3.rsp_valid) begin
        if (nrsp < 4) begin
          rsp_cyc[nrsp] = c;
          rsp_dat[nrsp] = b3.rsp_rdata;
        end
        nrsp++;
      end
      acc = b3.req_valid && b3.req_ready;
      if (!b3.req_ready) low_cnt++;
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        if (nacc < 4) begin
          b3.req_we    = req_w[nacc];
          b3.req_addr  = req_a[nacc];
          b3.req_wdata = req_d[nacc];
        end else begin
          b3.req_valid = 1'b0;
        end
      end
    end
    chk("w3_nrsp", 32'(nrsp), 32'd4);
    chk("w3_nacc", 32'(nacc), 32'd4);
    if (nrsp == 4) begin
      chk("w3_lat0", 32'(rsp_cyc[0]), 32'd5);
      for (int k = 1; k < 4; k++) begin
        chk($sformatf("w3_period%0d", k), 32'(rsp_cyc[k] - rsp_cyc[k-1]), 32'd5);
      end
      chk("w3_st0", rsp_dat[0], 32'd0);
      chk("w3_st1", rsp_dat[1], 32'd0);
      chk("w3_ld0", rsp_dat[2], 32'h11111111);
      chk("w3_ld1", rsp_dat[3], 32'h22222222);
    end
    chk("w3_ready_low", 32'(low_cnt), 32'd16);

    n = nerr;
    $display("Result: errors=%0d of %0d checks", n, nchk);
    $finish;
  end

endmodule

`default_nettype wire
